// File: rtl/bus_arbiter_4_pkg.sv
// Shared types and constants for the 4-requester round-robin bus arbiter.
package bus_arbiter_4_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned IDX_W            = 2;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned MAX_HOLD_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Round-robin pick: first set request scanning upward from last+1 (mod 4).
  // The last owner itself is considered only after every other requester.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_4_mux.sv
// Shared data-path multiplexer: selects I[S] when enabled, drives zero otherwise.
module mux_4NtoN #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  input  logic [N-1:0] I2,
  input  logic [N-1:0] I3,
  input  logic [1:0]   S,
  input  logic         enable,
  output logic [N-1:0] O
);

  always_comb begin
    O = '0;
    if (enable) begin
      case (S)
        2'd0:    O = I0;
        2'd1:    O = I1;
        2'd2:    O = I2;
        default: O = I3;
      endcase
    end
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Four-requester round-robin bus arbiter with hold limit and one-cycle turnaround.
module bus_arbiter_4
  import bus_arbiter_4_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  input  logic [N-1:0]       I0,
  input  logic [N-1:0]       I1,
  input  logic [N-1:0]       I2,
  input  logic [N-1:0]       I3,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   S,
  output logic               enable,
  output logic [N-1:0]       O,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   s_q, s_d;
  logic               enable_q, enable_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;

  logic [IDX_W-1:0]   winner;
  logic               owner_req;
  logic               owner_done;
  logic               expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      s_q          <= '0;
      enable_q     <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      s_q          <= s_d;
      enable_q     <= enable_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    s_d          = s_q;
    enable_d     = enable_q;
    timeout_d    = 1'b0;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;

    winner     = rr_pick(req, last_owner_q);
    owner_req  = req[s_q];
    owner_done = done[s_q];
    expired    = (cnt_q == HOLD_MAX);

    case (state_q)
      IDLE: begin
        grant_d  = '0;
        enable_d = 1'b0;
        if (|req) begin
          state_d      = GRANT;
          grant_d      = NUM_REQ'(1) << winner;
          s_d          = winner;
          enable_d     = 1'b1;
          last_owner_d = winner;
          cnt_d        = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!expired) cnt_d = cnt_q + CNT_W'(1);
        // done and a dropped request both take precedence over hold expiry
        if (!owner_req || owner_done || expired) begin
          state_d   = RELEASE;
          grant_d   = '0;
          enable_d  = 1'b0;
          cnt_d     = '0;
          timeout_d = expired && owner_req && !owner_done;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        grant_d  = '0;
        enable_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        enable_d = 1'b0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign S       = s_q;
  assign enable  = enable_q;
  assign timeout = timeout_q;

  mux_4NtoN #(.N(N)) u_mux (
    .I0     (I0),
    .I1     (I1),
    .I2     (I2),
    .I3     (I3),
    .S      (s_q),
    .enable (enable_q),
    .O      (O)
  );

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter N, default 32, width of each requester data word and of the shared output.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive GRANT cycles per ownership (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req  input  4  request per requester; bit i high = requester i wants the shared path.
REQ-006 done  input  4  bit i high = requester i finishes its transfer this cycle; ignored unless i is owner.
REQ-007 I0, I1, I2, I3  input  N each  requester data words.
REQ-008 grant  output  4  one-hot owner indication; all zero when no owner.
REQ-009 S  output  2  registered owner index; drives the shared mux select.
REQ-010 enable  output  1  high exactly when grant is non-zero.
REQ-011 O  output  N  shared data path: I[S] when enable=1, all zeros when enable=0.
REQ-012 timeout  output  1  one-cycle pulse when an ownership is revoked by MAX_HOLD expiry.

Function
REQ-013 The block SHALL implement states IDLE, GRANT, RELEASE.
REQ-014 IDLE: grant=0, enable=0; if any req bit is high at edge k, SHALL enter GRANT with grant valid after edge k (one-cycle latency from req to grant).
REQ-015 Winner SHALL be chosen round-robin: first set req bit scanning upward (mod 4) from last_owner+1.
REQ-016 On entering GRANT, last_owner SHALL update to the winner and hold counter SHALL load 1.
REQ-017 GRANT: grant, S, enable SHALL stay constant; hold counter SHALL increment each cycle, saturating at MAX_HOLD.
REQ-018 GRANT SHALL exit to RELEASE at the edge where req[owner]=0, or done[owner]=1, or counter equals MAX_HOLD.
REQ-019 timeout SHALL pulse high for the single RELEASE cycle only when exit was caused by counter expiry and neither req drop nor done was present that same cycle (done takes precedence over timeout).
REQ-020 RELEASE: grant=0, enable=0, O=0 for exactly one cycle (bus turnaround), then SHALL go to IDLE; requests seen in RELEASE are arbitrated from IDLE normally.
REQ-021 Requests from non-owners during GRANT SHALL be ignored (no preemption).
REQ-022 A requester holding req continuously SHALL not be regranted while any other requester is pending (fairness: max wait 3 ownerships).
REQ-023 req changes in the same cycle as the IDLE-to-GRANT decision SHALL use sampled values only; no combinational path from req to grant.
REQ-024 O SHALL be combinational from I0..I3, S, enable; all other outputs registered.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, grant=0, S=2'b00, enable=0, timeout=0, counter=0, last_owner=3 (requester 0 highest priority first).
REQ-026 Reset asserted mid-GRANT SHALL drop grant and enable on that edge with no RELEASE cycle and no timeout pulse.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, GRANT, RELEASE) and the MAX_HOLD default constant.
REQ-028 The data path SHALL be one instance of the existing mux_4NtoN sub-module driven by S and enable.

Verification
REQ-029 Reset then req=4'b0001, done held low, req held -> grant=0001, S=00, O=I0 one cycle later; after 8 GRANT cycles timeout=1 for one cycle, grant=0.
REQ-030 req=4'b1111 held, done pulsed each 2nd GRANT cycle -> owners in order 0,1,2,3,0, each separated by one RELEASE cycle with O=0.
REQ-031 Owner 2 in GRANT, req[1] asserted -> grant stays 0100 until done[2]=1; next owner 1; O equals I1=32'h28A44EAF.
REQ-032 Owner 0 drops req and asserts done same cycle -> RELEASE, timeout=0.
REQ-033 rst=1 during GRANT of requester 3 -> next cycle grant=0, enable=0, O=0, S=00; then req=4'b1001 -> grant=0001.
REQ-034 req=0 for 50 cycles after reset -> enable=0, O=0, timeout=0 throughout.
